banked_regfile: RTL

Parametrised successor to the CPU register file. Holds the accumulator/flag pair, NUM_PAIRS general register pairs replicated across NUM_BANKS banks, INDEX_REGS unbanked index registers and SP. Provides two combinational read ports (byte or pair), one write port, block-counter decrement with flag update, SP push/pop stepping and bank-rotating exchanges. Sits between the decoder/sequencer and the ALU/address unit.

---
 rtl/regfile_pkg.sv | 38 +++
 rtl/banked_regfile_if.sv | 50 +++++
 rtl/regfile_read_mux.sv | 47 ++++
 rtl/banked_regfile.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_pkg                                                |
// | Brief   : Index, flag-bit and control encodings for banked_regfile.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package regfile_pkg;

  localparam int c_PAIR_AF = 0;
  localparam int c_PAIR_BC = 1;
  localparam int c_PAIR_DE = 2;
  localparam int c_PAIR_HL = 3;

  localparam logic [1:0] c_SP_NONE = 2'b00;
  localparam logic [1:0] c_SP_INC  = 2'b01;
  localparam logic [1:0] c_SP_DEC  = 2'b10;

  localparam int c_FLAG_S  = 7;
  localparam int c_FLAG_Z  = 6;
  localparam int c_FLAG_H  = 4;
  localparam int c_FLAG_PV = 2;
  localparam int c_FLAG_N  = 1;
  localparam int c_FLAG_C  = 0;

  localparam logic c_CNT_LD = 1'b0;
  localparam logic c_CNT_CP = 1'b1;

  // First index pair follows the banked general pairs
  function automatic int ix0_pair(input int num_pairs);
    return num_pairs + 1;
  endfunction

  function automatic int sp_pair(input int num_pairs, input int index_regs);
    return num_pairs + index_regs + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/banked_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : banked_regfile_if                                          |
// | Brief   : Read/write/control bundle between sequencer and regfile.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface banked_regfile_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4,
  parameter int BANK_W = 1
);
  logic [SEL_W-1:0]    rd_sel_a;
  logic                rd_byte_a;
  logic [2*DATA_W-1:0] rd_data_a;
  logic [SEL_W-1:0]    rd_sel_b;
  logic                rd_byte_b;
  logic [2*DATA_W-1:0] rd_data_b;
  logic                wr_en;
  logic                wr_byte;
  logic [SEL_W-1:0]    wr_sel;
  logic [2*DATA_W-1:0] wr_data;
  logic                flags_we;
  logic [DATA_W-1:0]   flags_in;
  logic                cnt_dec;
  logic                cnt_mode;
  logic [1:0]          sp_step;
  logic                ex_dehl;
  logic                ex_af;
  logic                exx;
  logic [DATA_W-1:0]   flags_out;
  logic                cnt_zero;
  logic                b_zero;
  logic [BANK_W-1:0]   bank_gp;
  logic [BANK_W-1:0]   bank_af;

  modport master (
    output rd_sel_a, rd_byte_a, rd_sel_b, rd_byte_b,
    output wr_en, wr_byte, wr_sel, wr_data, flags_we, flags_in,
    output cnt_dec, cnt_mode, sp_step, ex_dehl, ex_af, exx,
    input  rd_data_a, rd_data_b, flags_out, cnt_zero, b_zero, bank_gp, bank_af
  );

  modport slave (
    input  rd_sel_a, rd_byte_a, rd_sel_b, rd_byte_b,
    input  wr_en, wr_byte, wr_sel, wr_data, flags_we, flags_in,
    input  cnt_dec, cnt_mode, sp_step, ex_dehl, ex_af, exx,
    output rd_data_a, rd_data_b, flags_out, cnt_zero, b_zero, bank_gp, bank_af
  );
endinterface
`default_nettype wire

// File: rtl/regfile_read_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_read_mux                                           |
// | Brief   : Pair/byte read select with optional same-cycle forwarding. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_read_mux #(
  parameter int DATA_W      = 8,
  parameter int NUM_ENTRIES = 7,
  parameter int SEL_W       = 4
) (
  input  wire logic [2*DATA_W-1:0] pairs [NUM_ENTRIES],
  input  wire logic [SEL_W-1:0]    sel,
  input  wire logic                rd_byte,
  input  wire logic                byp_en,
  input  wire logic                byp_byte,
  input  wire logic [SEL_W-1:0]    byp_sel,
  input  wire logic [2*DATA_W-1:0] byp_data,
  output logic      [2*DATA_W-1:0] data
);
  localparam int c_PW = 2 * DATA_W;

  logic [SEL_W-1:0] w_pidx;
  logic [SEL_W-1:0] w_byp_pidx;
  logic [c_PW-1:0]  w_pair;

  always_comb begin
    w_pidx     = rd_byte  ? {1'b0, sel[SEL_W-1:1]}     : sel;
    w_byp_pidx = byp_byte ? {1'b0, byp_sel[SEL_W-1:1]} : byp_sel;
    w_pair     = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_pidx == SEL_W'(i)) w_pair = pairs[i];
    end
    // Only the half actually written is forwarded on partial overlap
    if (byp_en && (w_byp_pidx == w_pidx) && (w_pidx < SEL_W'(NUM_ENTRIES))) begin
      if (!byp_byte || !byp_sel[0])
        w_pair[c_PW-1:DATA_W] = byp_byte ? byp_data[DATA_W-1:0] : byp_data[c_PW-1:DATA_W];
      if (!byp_byte || byp_sel[0])
        w_pair[DATA_W-1:0] = byp_data[DATA_W-1:0];
    end
  end

  assign data = rd_byte ? {{DATA_W{1'b0}}, (sel[0] ? w_pair[DATA_W-1:0] : w_pair[c_PW-1:DATA_W])}
                        : w_pair;

endmodule
`default_nettype wire

// File: rtl/banked_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : banked_regfile                                             |
// | Brief   : Banked CPU register file; define REGFILE_BYPASS_EN to      |
// |           forward same-cycle writes to the read ports.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module banked_regfile
  import regfile_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                NUM_PAIRS  = 3,
  parameter int                NUM_BANKS  = 2,
  parameter int                INDEX_REGS = 2,
  parameter int                SEL_W      = 4,
  parameter logic [DATA_W-1:0] FLAG_MASK  = 8'hD7
) (
  input wire logic        clk,
  input wire logic        n_reset,
  banked_regfile_if.slave bus
);
  localparam int c_PW     = 2 * DATA_W;
  localparam int c_NE     = NUM_PAIRS + INDEX_REGS + 2;
  localparam int c_BANK_W = $clog2(NUM_BANKS);
  localparam int c_IX0    = ix0_pair(NUM_PAIRS);
  localparam int c_SP     = sp_pair(NUM_PAIRS, INDEX_REGS);

  logic [c_PW-1:0]     r_af [NUM_BANKS];
  logic [c_PW-1:0]     r_gp [NUM_BANKS][NUM_PAIRS];
  logic [c_PW-1:0]     r_ix [INDEX_REGS];
  logic [c_PW-1:0]     r_sp;
  logic [c_BANK_W-1:0] r_bank_gp;
  logic [c_BANK_W-1:0] r_bank_af;

  logic [c_PW-1:0]  w_cur [c_NE];
  logic [c_PW-1:0]  w_nxt [c_NE];
  logic [SEL_W-1:0] w_wr_pidx;
  logic             w_wr_hi;
  logic             w_wr_lo;
  logic             w_ex_dehl;
  logic             w_drop;
  logic             w_byp_en;

  // Flat view of the currently visible pairs, indexed like the selectors
  always_comb begin
    w_cur[c_PAIR_AF] = r_af[r_bank_af];
    for (int i = 0; i < NUM_PAIRS; i++) w_cur[c_PAIR_BC + i] = r_gp[r_bank_gp][i];
    for (int i = 0; i < INDEX_REGS; i++) w_cur[c_IX0 + i] = r_ix[i];
    w_cur[c_SP] = r_sp;
  end

  assign w_ex_dehl = bus.ex_dehl && !bus.exx;
  assign w_wr_pidx = bus.wr_byte ? {1'b0, bus.wr_sel[SEL_W-1:1]} : bus.wr_sel;
  assign w_wr_hi   = !bus.wr_byte || !bus.wr_sel[0];
  assign w_wr_lo   = !bus.wr_byte ||  bus.wr_sel[0];

  // Later statements take priority: step/dec < flags_we < wr_en < cnt flags < exchange
  always_comb begin
    w_drop = 1'b0;
    for (int i = 0; i < c_NE; i++) w_nxt[i] = w_cur[i];
    if (bus.sp_step == c_SP_INC)      w_nxt[c_SP] = w_cur[c_SP] + c_PW'(2);
    else if (bus.sp_step == c_SP_DEC) w_nxt[c_SP] = w_cur[c_SP] - c_PW'(2);
    if (bus.cnt_dec && !bus.exx) w_nxt[c_PAIR_BC] = w_cur[c_PAIR_BC] - c_PW'(1);
    if (bus.flags_we && !bus.ex_af) w_nxt[c_PAIR_AF][DATA_W-1:0] = bus.flags_in & FLAG_MASK;
    for (int i = 0; i < c_NE; i++) begin
      w_drop = ((i == c_PAIR_AF) && bus.ex_af) ||
               ((i >= c_PAIR_BC) && (i <= NUM_PAIRS) && bus.exx) ||
               (((i == c_PAIR_DE) || (i == c_PAIR_HL)) && w_ex_dehl);
      if (bus.wr_en && (w_wr_pidx == SEL_W'(i)) && !w_drop) begin
        if (w_wr_hi)
          w_nxt[i][c_PW-1:DATA_W] = bus.wr_byte ? bus.wr_data[DATA_W-1:0]
                                                : bus.wr_data[c_PW-1:DATA_W];
        if (w_wr_lo) w_nxt[i][DATA_W-1:0] = bus.wr_data[DATA_W-1:0];
      end
    end
    if (bus.cnt_dec && !bus.ex_af) begin
      w_nxt[c_PAIR_AF][c_FLAG_PV] = (w_cur[c_PAIR_BC] != c_PW'(1));
      if (bus.cnt_mode == c_CNT_LD) begin
        w_nxt[c_PAIR_AF][c_FLAG_H] = 1'b0;
        w_nxt[c_PAIR_AF][c_FLAG_N] = 1'b0;
      end
    end
    if (w_ex_dehl) begin
      w_nxt[c_PAIR_DE] = w_cur[c_PAIR_HL];
      w_nxt[c_PAIR_HL] = w_cur[c_PAIR_DE];
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_af[b] <= '0;
        for (int i = 0; i < NUM_PAIRS; i++) r_gp[b][i] <= '0;
      end
      for (int i = 0; i < INDEX_REGS; i++) r_ix[i] <= '0;
      r_sp      <= '0;
      r_bank_gp <= '0;
      r_bank_af <= '0;
    end else begin
      r_af[r_bank_af] <= w_nxt[c_PAIR_AF];
      for (int i = 0; i < NUM_PAIRS; i++) r_gp[r_bank_gp][i] <= w_nxt[c_PAIR_BC + i];
      for (int i = 0; i < INDEX_REGS; i++) r_ix[i] <= w_nxt[c_IX0 + i];
      r_sp <= w_nxt[c_SP];
      if (bus.ex_af) r_bank_af <= r_bank_af + c_BANK_W'(1);
      if (bus.exx)   r_bank_gp <= r_bank_gp + c_BANK_W'(1);
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_byp_en = bus.wr_en;
`else
  assign w_byp_en = 1'b0;
`endif

  regfile_read_mux #(.DATA_W(DATA_W), .NUM_ENTRIES(c_NE), .SEL_W(SEL_W)) u_mux_a (
    .pairs    (w_cur),
    .sel      (bus.rd_sel_a),
    .rd_byte  (bus.rd_byte_a),
    .byp_en   (w_byp_en),
    .byp_byte (bus.wr_byte),
    .byp_sel  (bus.wr_sel),
    .byp_data (bus.wr_data),
    .data     (bus.rd_data_a)
  );

  regfile_read_mux #(.DATA_W(DATA_W), .NUM_ENTRIES(c_NE), .SEL_W(SEL_W)) u_mux_b (
    .pairs    (w_cur),
    .sel      (bus.rd_sel_b),
    .rd_byte  (bus.rd_byte_b),
    .byp_en   (w_byp_en),
    .byp_byte (bus.wr_byte),
    .byp_sel  (bus.wr_sel),
    .byp_data (bus.wr_data),
    .data     (bus.rd_data_b)
  );

  assign bus.flags_out = w_cur[c_PAIR_AF][DATA_W-1:0];
  assign bus.cnt_zero  = (w_cur[c_PAIR_BC] == '0);
  assign bus.b_zero    = (w_cur[c_PAIR_BC][c_PW-1:DATA_W] == '0);
  assign bus.bank_gp   = r_bank_gp;
  assign bus.bank_af   = r_bank_af;

endmodule
`default_nettype wire
